// File: rtl/sound_sequencer_if.sv
// CPU register bus and sound-engine write port of the sound sequencer.
interface sound_sequencer_if;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_data_in;
    logic       cpu_write;
    logic [7:0] cpu_data_out;
    logic [3:0] snd_addr;
    logic [7:0] snd_data;
    logic       snd_write;
    logic       snd_playing;

    modport master (
        output cpu_addr, cpu_data_in, cpu_write, snd_playing,
        input  cpu_data_out, snd_addr, snd_data, snd_write
    );

    modport slave (
        input  cpu_addr, cpu_data_in, cpu_write, snd_playing,
        output cpu_data_out, snd_addr, snd_data, snd_write
    );
endinterface

// File: rtl/sound_sequencer.sv
// Queues sample ids from the CPU and programs the sound engine from a
// descriptor table, one sample at a time.
module sound_sequencer #(
    parameter int QUEUE_DEPTH   = 4,
    parameter int TABLE_ENTRIES = 16
) (
    input logic clk,
    input logic reset,
    sound_sequencer_if.slave bus
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int IW = $clog2(TABLE_ENTRIES);

    typedef enum logic [2:0] {
        IDLE, LOAD, WAIT_START, PLAYING, STOP
    } state_e;

    state_e         state_q;
    logic [2:0]     step_q;
    logic [1:0]     wait_q;
    logic [15:0]    start_q, end_q;
    logic           err_q, ovf_q, ovf_d;
    logic           snd_we_q;
    logic [3:0]     snd_addr_q;
    logic [7:0]     snd_data_q;

    logic [15:0]    tab_start_q [TABLE_ENTRIES];
    logic [15:0]    tab_end_q   [TABLE_ENTRIES];
    logic [IW-1:0]  index_q;

    logic [3:0]     q_mem_q [QUEUE_DEPTH];
    logic [PW-1:0]  head_q, head_d, tail_q, tail_d, q_wa;
    logic [2:0]     count_q, count_d;
    logic           q_we;

    logic       wr_enq, wr_flush, wr_clr, busy, preempt, pop, full;
    logic [3:0] head_id;

    assign wr_enq   = bus.cpu_write && bus.cpu_addr == 4'd8;
    assign wr_flush = bus.cpu_write && bus.cpu_addr == 4'd9;
    assign wr_clr   = bus.cpu_write && bus.cpu_addr == 4'd10;
    assign busy     = state_q != IDLE;
    assign full     = count_q == 3'(QUEUE_DEPTH);
    assign pop      = state_q == IDLE && count_q != 3'd0;
    assign head_id  = q_mem_q[head_q];
    assign preempt  = wr_enq && bus.cpu_data_in[7] &&
                      (state_q == LOAD || state_q == WAIT_START ||
                       state_q == PLAYING);

    assign bus.cpu_data_out = {busy, full, count_q == 3'd0,
                               ovf_q, err_q, count_q};
    assign bus.snd_write = snd_we_q;
    assign bus.snd_addr  = snd_addr_q;
    assign bus.snd_data  = snd_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            index_q <= '0;
            for (int i = 0; i < TABLE_ENTRIES; i++) begin
                tab_start_q[i] <= '0;
                tab_end_q[i]   <= '0;
            end
        end else if (bus.cpu_write) begin
            unique case (bus.cpu_addr)
                4'd0: index_q <= bus.cpu_data_in[IW-1:0];
                4'd1: tab_start_q[index_q][7:0]  <= bus.cpu_data_in;
                4'd2: tab_start_q[index_q][15:8] <= bus.cpu_data_in;
                4'd3: tab_end_q[index_q][7:0]    <= bus.cpu_data_in;
                4'd4: tab_end_q[index_q][15:8]   <= bus.cpu_data_in;
                default: ;
            endcase
        end
    end

    // Pop happens first; the CPU write then acts on the popped queue.
    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q;
        count_d = count_q - 3'(pop);
        ovf_d   = ovf_q;
        q_we    = 1'b0;
        q_wa    = tail_q;
        if (wr_clr) ovf_d = 1'b0;
        if (wr_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = 3'd0;
        end else if (preempt) begin
            q_we    = 1'b1;
            q_wa    = '0;
            head_d  = '0;
            tail_d  = PW'(1);
            count_d = 3'd1;
        end else if (wr_enq) begin
            if (count_d == 3'(QUEUE_DEPTH)) begin
                ovf_d = 1'b1;
            end else begin
                q_we    = 1'b1;
                tail_d  = tail_q + PW'(1);
                count_d = count_d + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 3'd0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < QUEUE_DEPTH; i++) q_mem_q[i] <= 4'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (q_we) q_mem_q[q_wa] <= bus.cpu_data_in[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            step_q     <= 3'd0;
            wait_q     <= 2'd0;
            start_q    <= 16'd0;
            end_q      <= 16'd0;
            err_q      <= 1'b0;
            snd_we_q   <= 1'b0;
            snd_addr_q <= 4'd0;
            snd_data_q <= 8'd0;
        end else begin
            snd_we_q   <= 1'b0;
            snd_addr_q <= 4'd0;
            snd_data_q <= 8'd0;
            if (wr_clr) err_q <= 1'b0;
            if (wr_flush && busy) begin
                state_q    <= STOP;
                snd_we_q   <= 1'b1;
                snd_addr_q <= 4'd12;
            end else if (preempt) begin
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: if (pop) begin
                        start_q    <= tab_start_q[head_id];
                        end_q      <= tab_end_q[head_id];
                        snd_we_q   <= 1'b1;
                        snd_data_q <= tab_start_q[head_id][7:0];
                        step_q     <= 3'd0;
                        state_q    <= LOAD;
                    end
                    LOAD: if (step_q == 3'd4) begin
                        wait_q  <= 2'd0;
                        state_q <= WAIT_START;
                    end else begin
                        step_q   <= step_q + 3'd1;
                        snd_we_q <= 1'b1;
                        unique case (step_q)
                            3'd0: begin
                                snd_addr_q <= 4'd1;
                                snd_data_q <= start_q[15:8];
                            end
                            3'd1: begin
                                snd_addr_q <= 4'd4;
                                snd_data_q <= end_q[7:0];
                            end
                            3'd2: begin
                                snd_addr_q <= 4'd5;
                                snd_data_q <= end_q[15:8];
                            end
                            default: snd_addr_q <= 4'd8;
                        endcase
                    end
                    WAIT_START: begin
                        if (bus.snd_playing) begin
                            state_q <= PLAYING;
                        end else if (wait_q == 2'd3) begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            wait_q <= wait_q + 2'd1;
                        end
                    end
                    PLAYING: if (!bus.snd_playing) state_q <= IDLE;
                    STOP:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sound_sequencer.sv
// Directed scenario bench for sound_sequencer.
module tb_sound_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    sound_sequencer_if bus();

    sound_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] ea [5];
    logic [7:0] ed [5];

    task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
        bus.cpu_addr    = a;
        bus.cpu_data_in = d;
        bus.cpu_write   = 1'b1;
        @(negedge clk);
        bus.cpu_write   = 1'b0;
        bus.cpu_addr    = 4'd0;
        bus.cpu_data_in = 8'd0;
    endtask

    task automatic prog(input logic [3:0] idx, input logic [15:0] s,
                        input logic [15:0] e);
        cpu_wr(4'd0, {4'd0, idx});
        cpu_wr(4'd1, s[7:0]);
        cpu_wr(4'd2, s[15:8]);
        cpu_wr(4'd3, e[7:0]);
        cpu_wr(4'd4, e[15:8]);
    endtask

    task automatic apply_reset();
        bus.snd_playing = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic start_play(input logic [3:0] id);
        cpu_wr(4'd8, {4'd0, id});
        repeat (5) @(negedge clk);
        bus.snd_playing = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_writes(input string nm);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.snd_write !== 1'b1 || bus.snd_addr !== ea[i] ||
                bus.snd_data !== ed[i]) begin
                errors++;
                $display("FAIL %s[%0d]: got w=%b a=%0d d=%h want a=%0d d=%h",
                         nm, i, bus.snd_write, bus.snd_addr, bus.snd_data,
                         ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (bus.cpu_data_out !== 8'h20 || bus.snd_write !== 1'b0 ||
            bus.snd_addr !== 4'd0 || bus.snd_data !== 8'd0) begin
            errors++;
            $display("FAIL reset: status=%h w=%b a=%h d=%h want 20/0/0/0",
                     bus.cpu_data_out, bus.snd_write, bus.snd_addr,
                     bus.snd_data);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        prog(4'd3, 16'h1200, 16'h12FF);
        cpu_wr(4'd8, 8'd3);
        checks++;
        if (bus.snd_write !== 1'b0) begin
            errors++;
            $display("FAIL basic_n1: snd_write=%b want 0", bus.snd_write);
        end
        ea = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd8};
        ed = '{8'h00, 8'h12, 8'hFF, 8'h12, 8'h00};
        check_writes("basic_load");
        bus.snd_playing = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (bus.cpu_data_out !== 8'hA0 || bus.snd_write !== 1'b0) begin
            errors++;
            $display("FAIL basic_play: status=%h w=%b want A0/0",
                     bus.cpu_data_out, bus.snd_write);
        end
        bus.snd_playing = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cpu_data_out !== 8'h20) begin
            errors++;
            $display("FAIL basic_idle: status=%h want 20", bus.cpu_data_out);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        prog(4'd3, 16'h1200, 16'h12FF);
        start_play(4'd3);
        cpu_wr(4'd8, 8'd1);
        cpu_wr(4'd8, 8'd2);
        cpu_wr(4'd8, 8'd4);
        cpu_wr(4'd8, 8'd5);
        cpu_wr(4'd8, 8'd6);
        checks++;
        if (bus.cpu_data_out !== 8'hD4) begin
            errors++;
            $display("FAIL ovf_set: status=%h want D4", bus.cpu_data_out);
        end
        cpu_wr(4'd10, 8'd0);
        checks++;
        if (bus.cpu_data_out !== 8'hC4) begin
            errors++;
            $display("FAIL ovf_clr: status=%h want C4", bus.cpu_data_out);
        end
        bus.snd_playing = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cpu_data_out !== 8'h44) begin
            errors++;
            $display("FAIL full_idle: status=%h want 44", bus.cpu_data_out);
        end
        cpu_wr(4'd8, 8'd9);
        checks++;
        if (bus.cpu_data_out !== 8'hC4 || bus.snd_write !== 1'b1) begin
            errors++;
            $display("FAIL full_pop_enq: status=%h w=%b want C4/1",
                     bus.cpu_data_out, bus.snd_write);
        end
    endtask

    task automatic test_preempt();
        apply_reset();
        prog(4'd3, 16'h1200, 16'h12FF);
        prog(4'd7, 16'hA0B0, 16'hC0D0);
        start_play(4'd3);
        cpu_wr(4'd8, 8'd1);
        cpu_wr(4'd8, 8'd2);
        checks++;
        if (bus.cpu_data_out !== 8'h82) begin
            errors++;
            $display("FAIL pre_queued: status=%h want 82", bus.cpu_data_out);
        end
        cpu_wr(4'd8, 8'h87);
        checks++;
        if (bus.cpu_data_out !== 8'h01 || bus.snd_write !== 1'b0) begin
            errors++;
            $display("FAIL pre_idle: status=%h w=%b want 01/0",
                     bus.cpu_data_out, bus.snd_write);
        end
        ea = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd8};
        ed = '{8'hB0, 8'hA0, 8'hD0, 8'hC0, 8'h00};
        check_writes("pre_load");
        checks++;
        if (bus.cpu_data_out !== 8'hA0) begin
            errors++;
            $display("FAIL pre_count: status=%h want A0", bus.cpu_data_out);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        prog(4'd2, 16'h0102, 16'h0304);
        cpu_wr(4'd8, 8'd2);
        ea = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd8};
        ed = '{8'h02, 8'h01, 8'h04, 8'h03, 8'h00};
        check_writes("to_load");
        repeat (4) @(negedge clk);
        checks++;
        if (bus.cpu_data_out !== 8'hA0) begin
            errors++;
            $display("FAIL to_wait4: status=%h want A0", bus.cpu_data_out);
        end
        @(negedge clk);
        checks++;
        if (bus.cpu_data_out !== 8'h28) begin
            errors++;
            $display("FAIL to_err: status=%h want 28", bus.cpu_data_out);
        end
        cpu_wr(4'd10, 8'd0);
        checks++;
        if (bus.cpu_data_out !== 8'h20) begin
            errors++;
            $display("FAIL to_clr: status=%h want 20", bus.cpu_data_out);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        prog(4'd3, 16'h1200, 16'h12FF);
        start_play(4'd3);
        cpu_wr(4'd8, 8'd1);
        cpu_wr(4'd9, 8'd0);
        checks++;
        if (bus.snd_write !== 1'b1 || bus.snd_addr !== 4'd12 ||
            bus.snd_data !== 8'h00 || bus.cpu_data_out !== 8'hA0) begin
            errors++;
            $display("FAIL fl_stop: w=%b a=%0d d=%h st=%h want 1/12/00/A0",
                     bus.snd_write, bus.snd_addr, bus.snd_data,
                     bus.cpu_data_out);
        end
        bus.snd_playing = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.snd_write !== 1'b0 || bus.cpu_data_out !== 8'h20) begin
            errors++;
            $display("FAIL fl_idle: w=%b st=%h want 0/20",
                     bus.snd_write, bus.cpu_data_out);
        end
        cpu_wr(4'd9, 8'd0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.snd_write !== 1'b0) begin
                errors++;
                $display("FAIL fl_idle_nowr[%0d]: w=%b want 0",
                         i, bus.snd_write);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_load();
        apply_reset();
        prog(4'd3, 16'h1200, 16'h12FF);
        cpu_wr(4'd8, 8'd3);
        @(negedge clk);
        checks++;
        if (bus.snd_write !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: w=%b want 1", bus.snd_write);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (bus.snd_write !== 1'b0) begin
                errors++;
                $display("FAIL rst_nowr[%0d]: w=%b want 0", i, bus.snd_write);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.cpu_data_out !== 8'h20) begin
            errors++;
            $display("FAIL rst_status: status=%h want 20", bus.cpu_data_out);
        end
    endtask

    initial begin
        bus.cpu_addr    = 4'd0;
        bus.cpu_data_in = 8'd0;
        bus.cpu_write   = 1'b0;
        bus.snd_playing = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_preempt();
        test_timeout();
        test_flush();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
